fifo_push_arbiter: RTL and testbench
====================================

Name: fifo_push_arbiter

Overview:
Shares one `fifo` write port between N requesters using round-robin arbitration. Each cycle it grants at most one requester and drives the FIFO `push`/`Din` pins from registers. It tracks FIFO occupancy with its own credit counter (pushes issued minus pops seen), so back-to-back pushes never overrun the FIFO. It sits between the producer blocks and the `fifo` instance; the FIFO consumer's `pop` is tapped into this block.

Parameters:
- bits, 8, data word width (matches fifo `bits`)
- depth, 4, FIFO capacity in words (matches fifo `depth`); power of two, ≥2
- nreq, 4, number of requesters; ≥2

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active low
- req  input  nreq  per-requester request; held high while the requester has a word to write
- din_req  input  nreq*bits  requester data, flattened; requester i uses bits [i*bits +: bits]
- ack  output  nreq  one-hot, one-cycle pulse: the requester's word was taken this cycle
- fifo_pop  input  1  same signal that drives the FIFO's `pop`
- fifo_push  output  1  drives the FIFO's `push`
- fifo_din  output  bits  drives the FIFO's `Din`
- grant_id  output  clog2(nreq)  index of the last granted requester; holds its value between grants
- credits  output  clog2(depth)+1  free committed slots, equal to depth-count

Behaviour:
- Reset (rst=0, async): fifo_push=0, fifo_din=0, ack=0, grant_id=0, count=0, credits=depth, rr_ptr=0.
- count holds committed words, range 0..depth, width clog2(depth)+1. It includes a push issued but not yet written into the FIFO.
- slot_ok = (count<depth) | (fifo_pop & count!=0). A pop sampled on the same edge frees a slot for that edge.
- Winner: the first i with req[i]=1, searching rr_ptr, rr_ptr+1, … mod nreq.
- At each rising edge, if slot_ok and |req:
  - fifo_push<=1, fifo_din<=din_req[winner], ack<=onehot(winner), grant_id<=winner.
  - rr_ptr<=winner+1, wrapping nreq-1→0.
- Otherwise: fifo_push<=0, ack<=0; fifo_din, grant_id and rr_ptr hold.
- Latency: a request is sampled at edge k. The data appears on fifo_push/fifo_din after edge k. The FIFO writes it at edge k+1.
- Requester rule: in the cycle where ack[i]=1, the requester must drop req[i] or present its next word. It may not re-present the same word.
- Count update at each edge:
  - count += (push issued this edge) − (fifo_pop & count!=0).
  - A simultaneous grant and pop leaves count unchanged.
- fifo_pop while count==0 is ignored (protocol error); count never underflows.
- Full: when count==depth and fifo_pop=0, there is no grant. Requests wait with no ack, and rr_ptr does not advance.
- Fairness: a continuously asserted req is granted within nreq grants.
- Reset mid-operation clears everything asynchronously; any in-flight push is dropped. The FIFO shares the same rst net, so both sides restart empty.
- credits is combinational from count.

Optional Feature:
- Macro: FIFO_ARB_PRIO0_EN.
- Defined: requester 0 has fixed highest priority. When req[0]=1 and slot_ok, it wins regardless of rr_ptr, and rr_ptr is not updated on its grants. Requesters 1..nreq-1 rotate round-robin among themselves.
- Undefined: pure round-robin across all requesters, as described in Behaviour.

Test Plan (bits=8, depth=4, nreq=4):
1. Reset, then req=4'b1111 with data 0x10, 0x11, 0x12, 0x13 and no pops → acks on requesters 0,1,2,3 in consecutive cycles; fifo_din sequence 0x10–0x13; credits 4→0; no fifo_push afterwards while req stays high.
2. Full (count=4), req[2]=1, fifo_pop=1 for one edge → grant to requester 2 on that same edge; count stays 4; credits stays 0.
3. req[1] and req[3] held high, fifo_pop=1 every cycle → grants alternate 1,3,1,3; grant_id follows; count constant.
4. Assert rst=0 mid-stream while fifo_push=1 → fifo_push, ack and count clear immediately; after release, the first grant goes to requester 0 if it is requesting.
5. fifo_pop=1 with count=0 → count stays 0, credits=4, no other effect.
6. FIFO_ARB_PRIO0_EN defined, req=4'b1111 with continuous pops → requester 0 wins every cycle; drop req[0] → requesters 1,2,3 rotate.

Source files
------------

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among nreq producers, with credit-based occupancy tracking.
// Optional macro FIFO_ARB_PRIO0_EN: requester 0 gets fixed top priority; the others rotate among themselves.
module fifo_push_arbiter #(
  parameter int unsigned bits  = 8,
  parameter int unsigned depth = 4,
  parameter int unsigned nreq  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [nreq-1:0]            req,
  input  logic [nreq*bits-1:0]       din_req,
  output logic [nreq-1:0]            ack,
  input  logic                       fifo_pop,
  output logic                       fifo_push,
  output logic [bits-1:0]            fifo_din,
  output logic [$clog2(nreq)-1:0]    grant_id,
  output logic [$clog2(depth):0]     credits
);

  localparam int unsigned ID_W  = $clog2(nreq);
  localparam int unsigned CNT_W = $clog2(depth) + 1;

  logic [CNT_W-1:0] count;
  logic [ID_W-1:0]  rr_ptr;

  logic             slot_ok_c;
  logic             pop_ok_c;
  logic             grant_c;
  logic             found_c;
  logic             upd_ptr_c;
  logic [ID_W-1:0]  idx_c;
  logic [ID_W-1:0]  win_c;
  logic [ID_W-1:0]  rr_nxt_c;
  logic [bits-1:0]  din_sel_c;
  logic [nreq-1:0]  ack_nxt_c;

  // A pop on the same edge frees a slot for that edge; pops on an empty count are ignored.
  assign pop_ok_c  = fifo_pop && (count != '0);
  assign slot_ok_c = (count < CNT_W'(depth)) || pop_ok_c;
  assign grant_c   = slot_ok_c && (|req);
  assign credits   = CNT_W'(depth) - count;

  // Winner search: first requester at or after rr_ptr, wrapping modulo nreq.
  always_comb begin
`ifdef FIFO_ARB_PRIO0_EN
    upd_ptr_c = !req[0];
`else
    upd_ptr_c = 1'b1;
`endif
    found_c = 1'b0;
    win_c   = rr_ptr;
    idx_c   = rr_ptr;
    for (int unsigned k = 0; k < nreq; k++) begin
      idx_c = ID_W'((32'(rr_ptr) + k) % nreq);
      if (!found_c && req[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
`ifdef FIFO_ARB_PRIO0_EN
    if (req[0]) begin
      win_c = '0;
    end
`endif
  end

  // Data mux, one-hot ack and pointer advance for the selected winner.
  always_comb begin
    din_sel_c = '0;
    ack_nxt_c = '0;
    for (int unsigned i = 0; i < nreq; i++) begin
      if (win_c == ID_W'(i)) begin
        din_sel_c    = din_req[i*bits +: bits];
        ack_nxt_c[i] = 1'b1;
      end
    end
    rr_nxt_c = (win_c == ID_W'(nreq - 1)) ? '0 : win_c + ID_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_push <= 1'b0;
      fifo_din  <= '0;
      ack       <= '0;
      grant_id  <= '0;
      rr_ptr    <= '0;
      count     <= '0;
    end else begin
      fifo_push <= grant_c;
      ack       <= grant_c ? ack_nxt_c : '0;
      if (grant_c) begin
        fifo_din <= din_sel_c;
        grant_id <= win_c;
        if (upd_ptr_c) begin
          rr_ptr <= rr_nxt_c;
        end
      end
      count <= count + CNT_W'(grant_c) - CNT_W'(pop_ok_c);
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed and randomized bench for fifo_push_arbiter against a queue-based reference model.
// Model expectations follow FIFO_ARB_PRIO0_EN when it is defined.
module tb_fifo_push_arbiter;

  localparam int N = 4;
  localparam int B = 8;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*B-1:0] din_req;
  logic [N-1:0]   ack;
  logic           fifo_pop;
  logic           fifo_push;
  logic [B-1:0]   fifo_din;
  logic [1:0]     grant_id;
  logic [2:0]     credits;

  fifo_push_arbiter #(.bits(B), .depth(D), .nreq(N)) dut (
    .clk(clk), .rst(rst), .req(req), .din_req(din_req), .ack(ack),
    .fifo_pop(fifo_pop), .fifo_push(fifo_push), .fifo_din(fifo_din),
    .grant_id(grant_id), .credits(credits)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: words committed to the FIFO, last round-robin winner, last output values.
  logic [B-1:0] q[$];
  int           last_rr;
  int           m_gid;
  logic [B-1:0] m_din;
  logic         m_push;
  logic [N-1:0] m_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_rr = N - 1;
    m_gid   = 0;
    m_din   = '0;
    m_push  = 1'b0;
    m_ack   = '0;
  endtask

  function automatic int pick(input logic [N-1:0] r);
    int w;
    w = -1;
`ifdef FIFO_ARB_PRIO0_EN
    if (r[0]) return 0;
    for (int k = 1; k < N; k++) begin
      int i;
      i = ((last_rr - 1 + k) % (N - 1)) + 1;
      if (w < 0 && r[i]) w = i;
    end
`else
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last_rr + k) % N;
      if (w < 0 && r[i]) w = i;
    end
`endif
    return w;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".push"},    32'(fifo_push), 32'(m_push));
    chk({tag, ".ack"},     32'(ack),       32'(m_ack));
    chk({tag, ".din"},     32'(fifo_din),  32'(m_din));
    chk({tag, ".gid"},     32'(grant_id),  32'(m_gid));
    chk({tag, ".credits"}, 32'(credits),   32'(D - q.size()));
  endtask

  // Apply one cycle of inputs, advance the model, then compare just after the edge.
  task automatic step(input string tag, input logic [N-1:0] r, input logic p, input logic [N*B-1:0] d);
    bit   slot;
    int   w;
    logic [B-1:0] word;
    req      = r;
    fifo_pop = p;
    din_req  = d;
    slot = (q.size() < D) || (p && q.size() != 0);
    w    = pick(r);
    if (p && q.size() != 0) void'(q.pop_front());
    if (slot && w >= 0) begin
      word = d[w*B +: B];
      q.push_back(word);
      m_push = 1'b1;
      m_ack  = N'(1) << w;
      m_din  = word;
      m_gid  = w;
`ifdef FIFO_ARB_PRIO0_EN
      if (w != 0) last_rr = w;
`else
      last_rr = w;
`endif
    end else begin
      m_push = 1'b0;
      m_ack  = '0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [N*B-1:0] d0;
    rst = 1'b0; req = '0; din_req = '0; fifo_pop = 1'b0;
    model_reset();
    #2;
    chk("rst.push",    32'(fifo_push), 32'd0);
    chk("rst.ack",     32'(ack),       32'd0);
    chk("rst.din",     32'(fifo_din),  32'd0);
    chk("rst.gid",     32'(grant_id),  32'd0);
    chk("rst.credits", 32'(credits),   32'd4);
    #10 rst = 1'b1;

    // Pop on an empty FIFO is ignored.
    step("pop_empty", 4'b0000, 1'b1, '0);
    chk("pop_empty.credits4", 32'(credits), 32'd4);

    // Fill from all requesters with no pops, then hold while full.
    d0 = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int c = 0; c < 4; c++) step("fill", 4'b1111, 1'b0, d0);
    chk("fill.credits0", 32'(credits), 32'd0);
    for (int c = 0; c < 3; c++) step("full_hold", 4'b1111, 1'b0, d0);
    chk("full_hold.nopush", 32'(fifo_push), 32'd0);

    // Pop while full lets a grant through on the same edge.
    step("full_pop", 4'b0100, 1'b1, {8'h23, 8'h22, 8'h21, 8'h20});
    chk("full_pop.credits0", 32'(credits), 32'd0);
    step("idle", 4'b0000, 1'b0, '0);

    // Two requesters under continuous pops.
    for (int c = 0; c < 6; c++)
      step("alt13", 4'b1010, 1'b1, {8'(8'h40 + c), 8'h00, 8'(8'h30 + c), 8'h00});

    // Reset while a push is in flight.
    step("pre_rst", 4'b1111, 1'b1, {8'h53, 8'h52, 8'h51, 8'h50});
    chk("pre_rst.push1", 32'(fifo_push), 32'd1);
    rst = 1'b0;
    model_reset();
    #1;
    check_outputs("mid_rst");
    #3 rst = 1'b1;
    step("post_rst", 4'b1111, 1'b0, {8'h63, 8'h62, 8'h61, 8'h60});
    chk("post_rst.ack0", 32'(ack), 32'd1);

`ifdef FIFO_ARB_PRIO0_EN
    // Requester 0 dominates; then the rest rotate.
    for (int c = 0; c < 4; c++) step("prio0", 4'b1111, 1'b1, {8'h73, 8'h72, 8'h71, 8'(8'h70 + c)});
    for (int c = 0; c < 6; c++) step("prio_rr", 4'b1110, 1'b1, {8'h83, 8'h82, 8'(8'h81 + c), 8'h80});
`endif

    // Randomized traffic.
    for (int c = 0; c < 400; c++)
      step("rand", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom);

    req = '0; fifo_pop = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
